led_blink_arbiter: RTL and testbench
====================================

Name: led_blink_arbiter

Overview:
Shares one status LED between NUM_REQ requesters. Each requester asks for a blink code: a half-period in clock cycles and a number of blinks. The block grants requesters in round-robin order and plays the granted code on the LED. After each code it inserts a fixed dark gap, then signals completion. It sits above the LED frequency divider logic and replaces fixed-rate toggling with arbitrated, programmable blink sequences.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
HP_W, 32, width of each half-period field in clock cycles
CNT_W, 8, width of each blink-count field
GAP_CYCLES, 25000000, dark cycles after every sequence (>=1; 0 is illegal and rejected at elaboration)

Ports:
pi_clk  in  1  clock, all logic on rising edge
pi_rst  in  1  synchronous, active-high reset
pi_req  in  NUM_REQ  per-requester request level
pi_half_period  in  NUM_REQ*HP_W  requester i half-period at [i*HP_W +: HP_W]
pi_blink_count  in  NUM_REQ*CNT_W  requester i blink count at [i*CNT_W +: CNT_W]
po_grant  out  NUM_REQ  one-hot owner of the LED, all-zero when idle
po_done  out  NUM_REQ  one-cycle pulse on the owner's bit at end of its sequence
po_busy  out  1  high while any sequence (including gap) is in progress
po_led  out  1  LED drive

Behaviour:
- Interface: one clock, pi_clk. Reset pi_rst is synchronous and active-high.
- Reset values: po_led=0, po_grant=0, po_done=0, po_busy=0, state=IDLE, rr pointer=0, all counters=0. Reset wins over every other event in the same cycle, including mid-sequence. It aborts the sequence with no po_done.
- All outputs are registered.
- FSM states: IDLE, ON, OFF, GAP.
- IDLE:
  - Pick the first asserted pi_req at or after rr pointer, searching upward with wrap.
  - If one exists, at the next edge:
    - latch owner index, hp = max(half_period, 1) and blinks = count;
    - po_grant = onehot(owner), po_busy = 1.
  - If blinks == 0, go to GAP with gap counter = GAP_CYCLES-1 and po_led=0.
  - Otherwise go to ON with po_led=1 and phase counter = hp-1.
  - If no request is asserted, stay in IDLE.
- ON: decrement the phase counter each cycle. When it is 0, go to OFF with po_led=0 and phase counter = hp-1. po_led is high exactly hp cycles per blink.
- OFF:
  - Decrement the phase counter each cycle.
  - When it is 0, decrement blinks.
  - If the remaining blinks are >0, go to ON with po_led=1 and phase counter = hp-1.
  - Otherwise go to GAP with gap counter = GAP_CYCLES-1.
- GAP:
  - po_led=0. Decrement the gap counter each cycle.
  - When it is 0, at the next edge: go to IDLE, po_done[owner]=1 for one cycle, po_grant=0, po_busy=0, rr pointer = (owner+1) mod NUM_REQ.
  - IDLE lasts at least one cycle between sequences.
- Latency: pi_req first sampled high in IDLE gives po_led=1 (count>0) and the grant on the following cycle.
- Sequence length, grant edge to done edge: 2*hp*blinks + GAP_CYCLES cycles.
- Inputs are sampled only at arbitration.
  - pi_req deassertion or field changes mid-sequence are ignored; the sequence completes and po_done still pulses.
  - A requester still asserting pi_req after done is re-arbitrated at lowest priority relative to the new pointer.
- Simultaneous requests resolve by the round-robin pointer only; there is no fixed priority.
- Counter arithmetic is unsigned with no wrap. Counters never decrement below 0 because each is reloaded on its 0 transition.

Test Plan:
(NUM_REQ=4, GAP_CYCLES=4 for all scenarios.)
1. Single blink sequence: reset, then req0 with hp=3, count=2 → po_grant=0001; po_led pattern 1,1,1,0,0,0,1,1,1,0,0,0; then 4 low cycles; po_done=0001 for one cycle 16 cycles after the grant edge; po_busy falls with it.
2. Simultaneous requests: all four req high from reset with hp=1, count=1 → grant order 0,1,2,3, each sequence 6 cycles plus 1 IDLE cycle. Then hold req0 and req2 → next grants 0, then 2.
3. Zero half-period: req1 with hp=0, count=3 → treated as hp=1; po_led 1,0,1,0,1,0, then gap, then po_done[1].
4. Zero blink count: req3 with count=0 → po_led never rises; po_grant=1000 for 4 gap cycles; po_done[3] pulses.
5. Request dropped mid-sequence: req2 dropped after the second ON cycle with hp=5, count=2 → full 20-cycle LED pattern plus gap; po_done[2] still pulses; no re-grant of 2.
6. Reset mid-sequence: pi_rst for 1 cycle during ON of owner 1 → next cycle po_led=0, po_grant=0, po_busy=0, no po_done. With req3 held, the next grant is 3 (pointer reset to 0, first asserted at or above 0).

Source files
------------

// File: rtl/led_blink_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : led_blink_arbiter
// Purpose  : Round-robin arbiter sharing one LED between requesters, each
//            playing a programmable blink code followed by a fixed dark gap.
// Revision : 1.0
// ============================================================================
module led_blink_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int HP_W       = 32,
    parameter int CNT_W      = 8,
    parameter int GAP_CYCLES = 25000000
) (
    input  logic                     pi_clk,
    input  logic                     pi_rst,
    input  logic [NUM_REQ-1:0]       pi_req,
    input  logic [NUM_REQ*HP_W-1:0]  pi_half_period,
    input  logic [NUM_REQ*CNT_W-1:0] pi_blink_count,
    output logic [NUM_REQ-1:0]       po_grant,
    output logic [NUM_REQ-1:0]       po_done,
    output logic                     po_busy,
    output logic                     po_led
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(GAP_CYCLES - 1);
    localparam logic [HP_W-1:0]    c_HP_ONE   = HP_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE  = CNT_W'(1);
    localparam logic [NUM_REQ-1:0] c_GRANT_0  = NUM_REQ'(1);

    generate
        if (GAP_CYCLES < 1) begin : g_bad_gap
            $error("led_blink_arbiter: GAP_CYCLES must be >= 1");
        end
        if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
            $error("led_blink_arbiter: NUM_REQ must be in 2..8");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t               state_q,  state_d;
    logic [c_IDX_W-1:0]   owner_q,  owner_d;
    logic [c_IDX_W-1:0]   rr_q,     rr_d;
    logic [HP_W-1:0]      hp_q,     hp_d;
    logic [CNT_W-1:0]     blinks_q, blinks_d;
    logic [HP_W-1:0]      phase_q,  phase_d;
    logic [c_GAP_W-1:0]   gap_q,    gap_d;
    logic                 led_q,    led_d;
    logic [NUM_REQ-1:0]   grant_q,  grant_d;
    logic [NUM_REQ-1:0]   done_q,   done_d;
    logic                 busy_q,   busy_d;

    logic                 found_w;
    logic [c_IDX_W-1:0]   pick_w;
    logic [HP_W-1:0]      hp_raw_w;
    logic [HP_W-1:0]      hp_sel_w;
    logic [CNT_W-1:0]     cnt_raw_w;

    // Walk offsets from highest to lowest so the nearest request at/after rr wins.
    always_comb begin : p_arb
        logic [c_IDX_W:0] idx;
        found_w = 1'b0;
        pick_w  = '0;
        idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_q} + (c_IDX_W + 1)'(k);
            if (idx >= (c_IDX_W + 1)'(NUM_REQ)) begin
                idx = idx - (c_IDX_W + 1)'(NUM_REQ);
            end
            if (pi_req[idx[c_IDX_W-1:0]]) begin
                found_w = 1'b1;
                pick_w  = idx[c_IDX_W-1:0];
            end
        end
    end

    always_comb begin
        hp_raw_w  = pi_half_period[pick_w * HP_W +: HP_W];
        cnt_raw_w = pi_blink_count[pick_w * CNT_W +: CNT_W];
        hp_sel_w  = (hp_raw_w == '0) ? c_HP_ONE : hp_raw_w;
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        hp_d     = hp_q;
        blinks_d = blinks_q;
        phase_d  = phase_q;
        gap_d    = gap_q;
        led_d    = led_q;
        grant_d  = grant_q;
        done_d   = '0;
        busy_d   = busy_q;

        case (state_q)
            S_IDLE: begin
                if (found_w) begin
                    owner_d  = pick_w;
                    hp_d     = hp_sel_w;
                    blinks_d = cnt_raw_w;
                    grant_d  = c_GRANT_0 << pick_w;
                    busy_d   = 1'b1;
                    if (cnt_raw_w == '0) begin
                        state_d = S_GAP;
                        gap_d   = c_GAP_LOAD;
                        led_d   = 1'b0;
                    end else begin
                        state_d = S_ON;
                        led_d   = 1'b1;
                        phase_d = hp_sel_w - c_HP_ONE;
                    end
                end
            end
            S_ON: begin
                if (phase_q == '0) begin
                    state_d = S_OFF;
                    led_d   = 1'b0;
                    phase_d = hp_q - c_HP_ONE;
                end else begin
                    phase_d = phase_q - c_HP_ONE;
                end
            end
            S_OFF: begin
                if (phase_q == '0) begin
                    blinks_d = blinks_q - c_CNT_ONE;
                    if (blinks_q > c_CNT_ONE) begin
                        state_d = S_ON;
                        led_d   = 1'b1;
                        phase_d = hp_q - c_HP_ONE;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = c_GAP_LOAD;
                    end
                end else begin
                    phase_d = phase_q - c_HP_ONE;
                end
            end
            S_GAP: begin
                led_d = 1'b0;
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = grant_q;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    rr_d    = (owner_q == c_IDX_W'(NUM_REQ - 1)) ? '0
                                                                  : owner_q + c_IDX_W'(1);
                end else begin
                    gap_d = gap_q - c_GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pi_clk) begin
        if (pi_rst) begin
            state_q  <= S_IDLE;
            owner_q  <= '0;
            rr_q     <= '0;
            hp_q     <= '0;
            blinks_q <= '0;
            phase_q  <= '0;
            gap_q    <= '0;
            led_q    <= 1'b0;
            grant_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            hp_q     <= hp_d;
            blinks_q <= blinks_d;
            phase_q  <= phase_d;
            gap_q    <= gap_d;
            led_q    <= led_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign po_led   = led_q;
    assign po_grant = grant_q;
    assign po_done  = done_q;
    assign po_busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_led_blink_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_blink_arbiter
// Purpose  : Directed self-checking bench for led_blink_arbiter.
// Revision : 1.0
// ============================================================================
module tb_led_blink_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int HP_W       = 8;
    localparam int CNT_W      = 8;
    localparam int GAP_CYCLES = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*HP_W-1:0]  hp;
    logic [NUM_REQ*CNT_W-1:0] cnt;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic                     led;

    int n_checks = 0;
    int n_errors = 0;

    led_blink_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .HP_W       (HP_W),
        .CNT_W      (CNT_W),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_dut (
        .pi_clk         (clk),
        .pi_rst         (rst),
        .pi_req         (req),
        .pi_half_period (hp),
        .pi_blink_count (cnt),
        .po_grant       (grant),
        .po_done        (done),
        .po_busy        (busy),
        .po_led         (led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_field(input int i, input int h, input int c);
        hp[i*HP_W +: HP_W]   = HP_W'(h);
        cnt[i*CNT_W +: CNT_W] = CNT_W'(c);
    endtask

    // Called on the cycle the grant is first visible; returns on the done cycle.
    task automatic check_seq(input int owner, input int hpe, input int bl, input int drop_at);
        logic [NUM_REQ-1:0] g_exp;
        int total;
        g_exp = NUM_REQ'(1) << owner;
        total = 2 * hpe * bl;
        if (drop_at == 0) req = '0;
        for (int c = 0; c < total; c++) begin
            if (drop_at > 0 && c == drop_at) begin
                req = '0;
                set_field(owner, 1, 1);
            end
            check("seq_grant", 32'(grant), 32'(g_exp));
            check("seq_led", 32'(led), 32'(((c / hpe) % 2) == 0));
            check("seq_busy", 32'(busy), 32'd1);
            check("seq_done", 32'(done), 32'd0);
            tick();
        end
        for (int g = 0; g < GAP_CYCLES; g++) begin
            check("gap_grant", 32'(grant), 32'(g_exp));
            check("gap_led", 32'(led), 32'd0);
            check("gap_busy", 32'(busy), 32'd1);
            check("gap_done", 32'(done), 32'd0);
            tick();
        end
        check("end_done", 32'(done), 32'(g_exp));
        check("end_grant", 32'(grant), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
        check("end_led", 32'(led), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        hp  = '0;
        cnt = '0;
        tick();
        tick();
        check("rst_led", 32'(led), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Scenario 1: single requester, hp=3, count=2
        rst = 1'b0;
        set_field(0, 3, 2);
        req = 4'b0001;
        tick();
        check_seq(0, 3, 2, 0);
        tick();
        check("s1_done_pulse", 32'(done), 32'd0);
        check("s1_idle_grant", 32'(grant), 32'd0);

        // Scenario 2: all requesters from reset, round-robin order
        rst = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) set_field(i, 1, 1);
        tick();
        rst = 1'b0;
        tick();
        check_seq(0, 1, 1, -1);
        tick();
        check_seq(1, 1, 1, -1);
        tick();
        check_seq(2, 1, 1, -1);
        tick();
        check_seq(3, 1, 1, -1);
        req = 4'b0101;
        tick();
        check_seq(0, 1, 1, -1);
        tick();
        check_seq(2, 1, 1, -1);
        req = '0;
        tick();
        check("s2_idle_grant", 32'(grant), 32'd0);

        // Scenario 3: zero half-period behaves as one
        set_field(1, 0, 3);
        req = 4'b0010;
        tick();
        check_seq(1, 1, 3, 0);
        tick();

        // Scenario 4: zero blink count, only the gap is played
        set_field(3, 5, 0);
        req = 4'b1000;
        tick();
        check_seq(3, 1, 0, 0);
        tick();

        // Scenario 5: request and fields dropped mid-sequence
        set_field(2, 5, 2);
        req = 4'b0100;
        tick();
        check_seq(2, 5, 2, 2);
        tick();
        check("s5_no_regrant", 32'(grant), 32'd0);
        check("s5_led", 32'(led), 32'd0);

        // Scenario 6: reset during ON of owner 1
        set_field(1, 4, 2);
        set_field(3, 2, 1);
        req = 4'b0010;
        tick();
        check("s6_grant1", 32'(grant), 32'b0010);
        check("s6_led_on", 32'(led), 32'd1);
        tick();
        req = 4'b1000;
        rst = 1'b1;
        tick();
        check("s6_rst_led", 32'(led), 32'd0);
        check("s6_rst_grant", 32'(grant), 32'd0);
        check("s6_rst_busy", 32'(busy), 32'd0);
        check("s6_rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();
        check_seq(3, 2, 1, 0);
        tick();
        check("s6_final_done", 32'(done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
